// File: rtl/tone_pkg.sv
// Shared types and widths for the tone generator and the score player.
package tone_pkg;

  localparam int unsigned TONE_FREQ_W = 16;
  localparam int unsigned TONE_CLK_HZ = 50000000;
  localparam int unsigned TONE_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    RUN
  } tone_state_e;

endpackage

// File: rtl/tone_divider.sv
// Serial restoring divider, one quotient bit per cycle.
module tone_divider
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W  = TONE_CNT_W,
  parameter int unsigned FREQ_W = TONE_FREQ_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_dividend,
  input  logic [FREQ_W:0]   i_divisor,
  output logic [CNT_W-1:0]  o_quotient,
  output logic              o_done,
  output logic              o_busy
);

  localparam int unsigned IW = $clog2(CNT_W);

  logic [CNT_W-1:0]  r_q;
  logic [FREQ_W:0]   r_rem;
  logic [FREQ_W:0]   r_dv;
  logic [IW-1:0]     r_cnt;
  logic              r_busy;

  logic [FREQ_W+1:0] w_sh;
  logic [FREQ_W:0]   w_df;
  logic [FREQ_W:0]   w_rn;
  logic [CNT_W-1:0]  w_qn;
  logic              w_ge;

  // remainder stays below the divisor, so FREQ_W+1 bits suffice
  assign w_sh = {r_rem, r_q[CNT_W-1]};
  assign w_ge = w_sh >= {1'b0, r_dv};
  assign w_df = w_sh[FREQ_W:0] - r_dv;
  assign w_rn = w_ge ? w_df : w_sh[FREQ_W:0];
  assign w_qn = {r_q[CNT_W-2:0], w_ge};

  assign o_quotient = w_qn;
  assign o_done     = r_busy && (r_cnt == IW'(CNT_W - 1));
  assign o_busy     = r_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_rem  <= '0;
      r_dv   <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_q    <= i_dividend;
      r_rem  <= '0;
      r_dv   <= i_divisor;
    end else if (r_busy) begin
      r_q   <= w_qn;
      r_rem <= w_rn;
      r_cnt <= r_cnt + IW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/tone_gen.sv
// Square-wave buzzer driver: Hz -> half-period via serial divide.
// TONE_GEN_DIFF_EN adds the complementary oAudioN piezo output.
module tone_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = TONE_CLK_HZ,
  parameter int unsigned FREQ_W = TONE_FREQ_W,
  parameter int unsigned CNT_W  = TONE_CNT_W
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic [FREQ_W-1:0] iFreq,
  output logic              oAudio,
  output logic              oBusy,
  output logic              oActive
`ifdef TONE_GEN_DIFF_EN
  ,
  output logic              oAudioN
`endif
);

  tone_state_e       r_state;
  logic [FREQ_W-1:0] r_fq;
  logic [CNT_W-1:0]  r_hp;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_audio;

  logic [CNT_W-1:0]  w_quot;
  logic              w_off;
  logic              w_start;
  logic              w_done;
  logic              w_busy;

  assign w_off = !iEnable || (iFreq == '0);
  // fq is zero whenever idle, so this also covers the first start
  assign w_start = !w_off && (iFreq != r_fq);

  tone_divider #(
    .CNT_W  (CNT_W),
    .FREQ_W (FREQ_W)
  ) u_div (
    .i_clk      (iClock),
    .i_rst      (iReset),
    .i_start    (w_start),
    .i_abort    (w_off),
    .i_dividend (CNT_W'(CLK_HZ)),
    .i_divisor  ({iFreq, 1'b0}),
    .o_quotient (w_quot),
    .o_done     (w_done),
    .o_busy     (w_busy)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= IDLE;
      r_fq    <= '0;
      r_hp    <= '0;
      r_cnt   <= '0;
      r_audio <= 1'b0;
    end else if (w_off) begin
      r_state <= IDLE;
      r_fq    <= '0;
      r_cnt   <= '0;
      r_audio <= 1'b0;
    end else if (w_start) begin
      r_state <= DIVIDE;
      r_fq    <= iFreq;
    end else begin
      unique case (r_state)
        DIVIDE: begin
          if (w_done) begin
            r_hp    <= (w_quot == '0) ? CNT_W'(1) : w_quot;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_cnt == r_hp - CNT_W'(1)) begin
            r_cnt   <= '0;
            r_audio <= !r_audio;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign oAudio  = r_audio;
  assign oBusy   = w_busy;
  assign oActive = (r_state == RUN);

`ifdef TONE_GEN_DIFF_EN
  assign oAudioN = (r_state != IDLE) && !r_audio;
`endif

endmodule
